// File: rtl/tpu_loader.sv
// Streams a block of words into TPU SRAM, then fires a one-cycle start pulse to the core.
// Handshake: a word transfers on any rising edge where s_valid and s_ready are both high.
module tpu_loader #(
  parameter int datawith = 16,
  parameter int addr_w   = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_req,
  input  logic [addr_w-1:0]   base_addr,
  input  logic [addr_w-1:0]   word_count,
  input  logic                s_valid,
  input  logic [datawith-1:0] s_data,
  output logic                s_ready,
  output logic [addr_w-1:0]   write_addr,
  output logic [datawith-1:0] data_out,
  output logic                write_en,
  output logic                tpu_start,
  output logic                busy,
  output logic                load_done,
  output logic                wrap_err
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, START} state_t;

  state_t              state, state_next;
  logic [addr_w-1:0]   ptr;
  logic [addr_w-1:0]   remaining;
  logic [addr_w-1:0]   count;
  logic                zero_done;
  logic                accept;
  logic                start_load;

  assign accept     = s_valid && s_ready;
  assign start_load = (state == IDLE) && load_req;

  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    busy       = 1'b0;
    tpu_start  = 1'b0;
    load_done  = zero_done;
    case (state)
      IDLE: begin
        if (load_req && (word_count != '0)) state_next = LOAD;
      end
      LOAD: begin
        busy    = 1'b1;
        s_ready = (remaining != '0);
        if (accept && (remaining == addr_w'(1))) state_next = FLUSH;
      end
      FLUSH: begin
        busy       = 1'b1;
        state_next = START;
      end
      START: begin
        busy       = 1'b1;
        tpu_start  = 1'b1;
        load_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      remaining  <= '0;
      count      <= '0;
      zero_done  <= 1'b0;
      write_en   <= 1'b0;
      write_addr <= '0;
      data_out   <= '0;
      wrap_err   <= 1'b0;
    end else begin
      state     <= state_next;
      write_en  <= accept;
      zero_done <= 1'b0;
      if (start_load) begin
        ptr       <= base_addr;
        remaining <= word_count;
        count     <= word_count;
        wrap_err  <= 1'b0;
        zero_done <= (word_count == '0);
      end
      if (accept) begin
        write_addr <= ptr;
        data_out   <= s_data;
        ptr        <= ptr + addr_w'(1);
        remaining  <= remaining - addr_w'(1);
        // Pointer at 0 on any word but the first means it rolled over the top of SRAM.
        if ((ptr == '0) && (remaining != count)) wrap_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tpu_loader.sv
// Directed-plus-random bench for tpu_loader against a cycle-level behavioural model.
module tb_tpu_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_req;
  logic [9:0]  base_addr;
  logic [9:0]  word_count;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic [9:0]  write_addr;
  logic [15:0] data_out;
  logic        write_en;
  logic        tpu_start;
  logic        busy;
  logic        load_done;
  logic        wrap_err;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [9:0] exp_q[$];

  // Model: phase 0 idle, 1 loading, 2 final write, 3 start pulse.
  int          m_phase = 0;
  int          m_base  = 0;
  int          m_count = 0;
  int          m_idx   = 0;
  logic        m_we    = 1'b0;
  logic [9:0]  m_wa    = '0;
  logic [15:0] m_wd    = '0;
  logic        m_wrap  = 1'b0;
  logic        m_zero  = 1'b0;

  tpu_loader #(.datawith(16), .addr_w(10)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .base_addr(base_addr),
    .word_count(word_count), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .write_addr(write_addr), .data_out(data_out),
    .write_en(write_en), .tpu_start(tpu_start), .busy(busy),
    .load_done(load_done), .wrap_err(wrap_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic lr, input logic [9:0] ba,
                            input logic [9:0] wc, input logic sv, input logic [15:0] sd);
    logic new_we;
    logic new_zero;
    new_we   = 1'b0;
    new_zero = 1'b0;
    if (r) begin
      m_phase = 0; m_we = 1'b0; m_wa = '0; m_wd = '0; m_wrap = 1'b0; m_zero = 1'b0;
      return;
    end
    case (m_phase)
      0: if (lr) begin
        m_wrap = 1'b0;
        if (wc == 0) new_zero = 1'b1;
        else begin
          m_base = int'(ba); m_count = int'(wc); m_idx = 0; m_phase = 1;
        end
      end
      1: if (sv) begin
        new_we = 1'b1;
        m_wa   = 10'((m_base + m_idx) % 1024);
        m_wd   = sd;
        if (m_base + m_idx >= 1024) m_wrap = 1'b1;
        m_idx++;
        if (m_idx == m_count) m_phase = 2;
      end
      2: m_phase = 3;
      default: m_phase = 0;
    endcase
    m_we   = new_we;
    m_zero = new_zero;
  endtask

  task automatic check_outputs();
    check("s_ready", s_ready, m_phase == 1);
    check("busy", busy, m_phase != 0);
    check("tpu_start", tpu_start, m_phase == 3);
    check("load_done", load_done, (m_phase == 3) || m_zero);
    check("write_en", write_en, m_we);
    check("write_addr", write_addr, m_wa);
    check("data_out", data_out, m_wd);
    check("wrap_err", wrap_err, m_wrap);
    if (write_en === 1'b1) begin
      if (exp_q.size() > 0) check("sb_addr", write_addr, exp_q.pop_front());
      else check("sb_extra_write", write_en, 1'b0);
    end
  endtask

  // Called at a falling edge; drives one cycle, then checks at the next falling edge.
  task automatic tick(input logic r, input logic lr, input logic [9:0] ba,
                      input logic [9:0] wc, input logic sv, input logic [15:0] sd);
    rst = r; load_req = lr; base_addr = ba; word_count = wc; s_valid = sv; s_data = sd;
    @(posedge clk);
    model_step(r, lr, ba, wc, sv, sd);
    @(negedge clk);
    check_outputs();
  endtask

  // vmode: 0 valid held high, 1 toggling, 2 random.
  task automatic run_load(input logic [9:0] ba, input logic [9:0] wc, input int vmode,
                          input logic [15:0] dbase, input int inject_at, input int rst_after);
    logic sv;
    logic lr;
    logic r;
    tick(1'b0, 1'b1, ba, wc, 1'b0, 16'h0);
    for (int i = 0; i < 64 && m_phase != 0; i++) begin
      sv = (vmode == 0) ? 1'b1 : (vmode == 1) ? (i % 2 == 0) : 1'($urandom_range(0, 1));
      lr = (i == inject_at);
      r  = (rst_after > 0) && (m_idx == rst_after);
      tick(r, lr, lr ? 10'h155 : ba, lr ? 10'd7 : wc, sv, dbase + 16'(m_idx));
    end
    check("bound_busy", busy, 1'b0);
    tick(1'b0, 1'b0, 10'h0, 10'h0, 1'($urandom_range(0, 1)), 16'($urandom));
    check("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [9:0] ba;
    logic [9:0] wc;
    rst = 1'b1; load_req = 1'b0; base_addr = '0; word_count = '0; s_valid = 1'b0; s_data = '0;
    @(negedge clk);
    tick(1'b1, 1'b0, 10'h0, 10'h0, 1'b0, 16'h0);
    tick(1'b1, 1'b1, 10'h3, 10'h3, 1'b1, 16'h1234);
    tick(1'b0, 1'b0, 10'h0, 10'h0, 1'b1, 16'h5555);

    // Basic load with held-high valid.
    for (int i = 0; i < 4; i++) exp_q.push_back(10'h010 + 10'(i));
    run_load(10'h010, 10'd4, 0, 16'hA000, -1, 0);

    // Back-pressure: valid 1,0,1,0,1.
    ba = 10'($urandom_range(0, 1000));
    for (int i = 0; i < 3; i++) exp_q.push_back(ba + 10'(i));
    run_load(ba, 10'd3, 1, 16'($urandom), -1, 0);

    // Wrap past the top of SRAM; flag must persist in idle.
    exp_q.push_back(10'h3FE); exp_q.push_back(10'h3FF);
    exp_q.push_back(10'h000); exp_q.push_back(10'h001);
    run_load(10'h3FE, 10'd4, 0, 16'($urandom), -1, 0);
    tick(1'b0, 1'b0, 10'h0, 10'h0, 1'b0, 16'h0);
    check("wrap_held", wrap_err, 1'b1);
    exp_q.push_back(10'h040); exp_q.push_back(10'h041);
    run_load(10'h040, 10'd2, 2, 16'($urandom), -1, 0);

    // Zero-count load, after re-arming the wrap flag.
    exp_q.push_back(10'h3FF); exp_q.push_back(10'h000);
    run_load(10'h3FF, 10'd2, 0, 16'($urandom), -1, 0);
    run_load(10'h100, 10'd0, 0, 16'h0, -1, 0);
    check("zero_clears_wrap", wrap_err, 1'b0);

    // load_req while busy must be ignored.
    for (int i = 0; i < 5; i++) exp_q.push_back(10'h080 + 10'(i));
    run_load(10'h080, 10'd5, 2, 16'($urandom), 2, 0);

    // Reset after the third accept, then a clean load.
    for (int i = 0; i < 3; i++) exp_q.push_back(10'h200 + 10'(i));
    run_load(10'h200, 10'd8, 0, 16'($urandom), -1, 3);
    check("rst_no_write", write_en, 1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back(10'h020 + 10'(i));
    run_load(10'h020, 10'd4, 2, 16'($urandom), -1, 0);

    // Random loads.
    for (int n = 0; n < 12; n++) begin
      ba = 10'($urandom_range(0, 1023));
      wc = 10'($urandom_range(1, 6));
      for (int i = 0; i < int'(wc); i++) exp_q.push_back(ba + 10'(i));
      run_load(ba, wc, 2, 16'($urandom), ($urandom_range(0, 3) == 0) ? 1 : -1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
